xs3_to_bin_seq: RTL and testbench
=================================

Name: xs3_to_bin_seq

Overview:
- Sequential multi-digit excess-3 to binary decoder. It is the inverse path of the team's binary-to-excess-3 encoder.
- Accepts DIGITS excess-3 digits, most significant digit first, one per accepted handshake, and accumulates them into an unsigned binary word.
- Checks every digit for a legal excess-3 code and flags the first illegal one.
- Sits between the XS-3 display/keypad datapath and the binary ALU inputs in the lab designs.

Parameters:
- DIGITS, default 4: number of excess-3 digits per conversion. Legal range is 1..8.
- OUT_W, default 14: binary result width. Must be at least ceil(log2(10^DIGITS)); 14 covers 9999.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to begin a conversion. Sampled only in IDLE.
- inp, input, 4: excess-3 digit. Legal codes are 4'b0011..4'b1100.
- in_valid, input, 1: inp holds a digit.
- in_ready, output, 1: block can accept a digit this cycle.
- op, output, OUT_W: binary result. Held until the next start.
- op_valid, output, 1: one-cycle pulse when op is updated.
- err, output, 1: illegal digit seen. Sticky until the next accepted start or reset.
- busy, output, 1: high in ACCUM and DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - acc=0, cnt=0.
  - op=0, op_valid=0, err=0, in_ready=0, busy=0.
  - A reset asserted mid-conversion discards the partial result. No op_valid is produced.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- State machine states: IDLE, ACCUM, DONE.
  - IDLE:
    - in_ready=0, busy=0.
    - start=1 moves to ACCUM next cycle and clears acc=0, cnt=0, err=0.
    - op keeps its previous value.
  - ACCUM:
    - in_ready=1, busy=1.
    - A digit is accepted on the clock edge where in_valid & in_ready.
    - in_valid=0 means hold: no state change, acc and cnt unchanged. Gaps of any length are allowed.
    - On an accepted legal digit: acc <= acc*10 + (inp - 3), cnt <= cnt+1.
    - acc*10 is computed as (acc<<3)+(acc<<1), truncated to OUT_W.
    - If the accepted digit is the DIGITS-th one (cnt == DIGITS-1 before the increment), go to DONE.
    - On an accepted illegal digit (inp < 3 or inp > 12): err <= 1 and go to IDLE immediately. acc is discarded, op is unchanged, and no op_valid is produced.
  - DONE:
    - op <= acc and op_valid=1 for exactly this one cycle.
    - in_ready=0, busy=1.
    - Go to IDLE on the next cycle.
- Latency: op_valid is asserted 1 cycle after the edge that accepted the last digit. A back-to-back conversion takes DIGITS+2 cycles from start to op_valid, with in_valid held high.
- Boundary rules:
  - start is ignored while busy=1. It is neither queued nor counted as a digit.
  - start and in_valid high together in IDLE: only start is acted on.
  - in_valid is ignored in IDLE and DONE.
  - The input value is irrelevant when in_valid=0, including X.
  - DIGITS=1: a single digit is accepted, then DONE.
  - Maximum input (all 4'b1100) yields 10^DIGITS-1 with no overflow when OUT_W is legal.
- Arithmetic: unsigned only. The digit value is inp-3, computed in 4 bits, after the legality check.

Test Plan:
1. Reset, then start, then digits 0100,0101,0110,0111 on consecutive cycles -> op=1234 (14'h04D2), op_valid pulse one cycle after the 4th digit, err=0, busy low the cycle after.
2. Digits 1100 x4 -> op=9999 (14'h270F). Then digits 0011 x4 -> op=0, with op_valid still pulsing.
3. Digits 0100, 1101 -> err=1 on the cycle after the 2nd digit, state IDLE, op keeps its prior value, no op_valid. Next start clears err; digits 0011,0011,0011,0100 -> op=1.
4. in_valid toggled 1,0,0,1,0,1,1 with digits 0100,0101,0110,0111 on the valid cycles -> op=1234. acc/cnt are unchanged during the gaps.
5. start pulsed again during ACCUM after 2 digits -> ignored; the conversion completes with the original digits. in_valid with inp=0100 in IDLE -> no effect.
6. rst_n pulled low after 2 digits (not clock-aligned) -> all outputs 0 immediately. After release, a fresh conversion of 0100,0100,0100,0100 gives op=1111.

Source files
------------

// File: rtl/xs3_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : xs3_to_bin_seq
// Brief    : Sequential excess-3 to binary decoder, MSD first, with
//            illegal-digit detection.
// Revision : 1.0 - initial release
// ============================================================================
module xs3_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       inp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] op,
    output logic             op_valid,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OUT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_op;
    logic               r_err;

    logic               w_start_ok;
    logic               w_take;
    logic               w_legal;
    logic               w_last;
    logic [3:0]         w_dig;
    logic [OUT_W-1:0]   w_acc_nxt;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_take     = (r_state == S_ACCUM) && in_valid;
    assign w_legal    = (inp >= 4'd3) && (inp <= 4'd12);
    assign w_last     = (r_cnt == c_last_cnt);
    assign w_dig      = inp - 4'd3;
    // acc*10 as shift-and-add, wrapping at OUT_W
    assign w_acc_nxt  = (r_acc << 3) + (r_acc << 1) + OUT_W'(w_dig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_take) begin
                    if (!w_legal) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // op is loaded on the final accepting edge so it is already stable
    // during the DONE cycle that raises op_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_op  <= '0;
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_take) begin
            if (!w_legal) begin
                r_err <= 1'b1;
            end else begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_op <= w_acc_nxt;
                end
            end
        end
    end

    assign in_ready = (r_state == S_ACCUM);
    assign busy     = (r_state != S_IDLE);
    assign op_valid = (r_state == S_DONE);
    assign op       = r_op;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xs3_to_bin_seq.sv
`default_nettype none
// Self-checking bench for xs3_to_bin_seq: directed scenarios plus randomized
// conversions compared against an arithmetic reference of the digit string.
module tb_xs3_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int OUT_W  = 14;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic             in_valid = 1'b0;
    logic [3:0]       inp      = 4'd0;
    logic             in_ready;
    logic [OUT_W-1:0] op;
    logic             op_valid;
    logic             err;
    logic             busy;

    always #5 clk = ~clk;

    xs3_to_bin_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inp      (inp),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .op_valid (op_valid),
        .err      (err),
        .busy     (busy)
    );

    int               total = 0;
    int               bad   = 0;
    logic [OUT_W-1:0] ref_op  = '0;
    logic             ref_err = 1'b0;
    logic [3:0]       dq   [DIGITS];
    int               gaps [DIGITS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input bit poke);
        for (int k = 0; k < n; k++) begin
            start    = 1'b0;
            in_valid = poke;
            inp      = 4'b0100;
            @(negedge clk);
            chk("idle_busy",  busy,     32'd0);
            chk("idle_ready", in_ready, 32'd0);
            chk("idle_valid", op_valid, 32'd0);
            chk("idle_op",    op,       ref_op);
            chk("idle_err",   err,      ref_err);
        end
        in_valid = 1'b0;
    endtask

    // Runs one conversion of dq[] with gaps[i] idle cycles before digit i.
    task automatic convert(input bit mid_start, input bit start_with_valid);
        longint val = 0;
        start    = 1'b1;
        in_valid = start_with_valid;
        inp      = 4'b0100;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        ref_err  = 1'b0;
        chk("start_busy",  busy,     32'd1);
        chk("start_ready", in_ready, 32'd1);
        chk("start_err",   err,      32'd0);
        for (int i = 0; i < DIGITS; i++) begin
            for (int k = 0; k < gaps[i]; k++) begin
                in_valid = 1'b0;
                inp      = ($urandom_range(1, 0) == 1) ? 4'bxxxx : 4'($urandom);
                @(negedge clk);
                chk("gap_ready", in_ready, 32'd1);
                chk("gap_valid", op_valid, 32'd0);
                chk("gap_op",    op,       ref_op);
            end
            start    = mid_start && (i == 2);
            in_valid = 1'b1;
            inp      = dq[i];
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            if (dq[i] < 4'd3 || dq[i] > 4'd12) begin
                ref_err = 1'b1;
                chk("bad_err",   err,      32'd1);
                chk("bad_busy",  busy,     32'd0);
                chk("bad_valid", op_valid, 32'd0);
                chk("bad_op",    op,       ref_op);
                return;
            end
            val = val * 10 + longint'(dq[i]) - 3;
            if (i < DIGITS - 1) begin
                chk("mid_busy",  busy,     32'd1);
                chk("mid_valid", op_valid, 32'd0);
            end else begin
                ref_op = OUT_W'(val);
                chk("done_valid", op_valid, 32'd1);
                chk("done_op",    op,       ref_op);
                chk("done_ready", in_ready, 32'd0);
                chk("done_busy",  busy,     32'd1);
                in_valid = 1'b1;
                inp      = 4'b0101;
                start    = 1'($urandom_range(1, 0));
                @(negedge clk);
                start    = 1'b0;
                in_valid = 1'b0;
                chk("post_valid", op_valid, 32'd0);
                chk("post_busy",  busy,     32'd0);
                chk("post_op",    op,       ref_op);
                chk("post_err",   err,      32'd0);
            end
        end
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        dq[0] = a; dq[1] = b; dq[2] = c; dq[3] = d;
        for (int i = 0; i < DIGITS; i++) gaps[i] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_op",    op,       32'd0);
        chk("rst_valid", op_valid, 32'd0);
        chk("rst_err",   err,      32'd0);
        chk("rst_ready", in_ready, 32'd0);
        chk("rst_busy",  busy,     32'd0);
        rst_n = 1'b1;
        idle_cycles(1, 1'b0);

        set_digits(4'b0100, 4'b0101, 4'b0110, 4'b0111);
        convert(1'b0, 1'b0);
        chk("t1_1234", op, 32'h04D2);

        set_digits(4'b1100, 4'b1100, 4'b1100, 4'b1100);
        convert(1'b0, 1'b0);
        chk("t2_9999", op, 32'h270F);
        set_digits(4'b0011, 4'b0011, 4'b0011, 4'b0011);
        convert(1'b0, 1'b0);
        chk("t2_zero", op, 32'd0);

        set_digits(4'b0100, 4'b1101, 4'b0011, 4'b0011);
        convert(1'b0, 1'b0);
        chk("t3_err", err, 32'd1);
        idle_cycles(2, 1'b1);
        set_digits(4'b0011, 4'b0011, 4'b0011, 4'b0100);
        convert(1'b0, 1'b0);
        chk("t3_one", op, 32'd1);

        set_digits(4'b0100, 4'b0101, 4'b0110, 4'b0111);
        gaps[1] = 2; gaps[2] = 1;
        convert(1'b0, 1'b0);
        chk("t4_gaps", op, 32'h04D2);

        set_digits(4'b0100, 4'b0101, 4'b0110, 4'b0111);
        gaps[2] = 1;
        convert(1'b1, 1'b1);
        chk("t5_mid_start", op, 32'h04D2);
        idle_cycles(3, 1'b1);

        // asynchronous reset part-way through a conversion
        set_digits(4'b0100, 4'b0101, 4'b0110, 4'b0111);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        inp      = 4'b0100;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_op",    op,       32'd0);
        chk("ar_valid", op_valid, 32'd0);
        chk("ar_err",   err,      32'd0);
        chk("ar_ready", in_ready, 32'd0);
        chk("ar_busy",  busy,     32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        ref_op  = '0;
        ref_err = 1'b0;
        idle_cycles(1, 1'b0);
        set_digits(4'b0100, 4'b0100, 4'b0100, 4'b0100);
        convert(1'b0, 1'b0);
        chk("t6_1111", op, 32'd1111);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(9, 0) == 0) begin
                    case ($urandom_range(5, 0))
                        0: dq[i] = 4'd0;
                        1: dq[i] = 4'd1;
                        2: dq[i] = 4'd2;
                        3: dq[i] = 4'd13;
                        4: dq[i] = 4'd14;
                        default: dq[i] = 4'd15;
                    endcase
                end else begin
                    dq[i] = 4'(3 + $urandom_range(9, 0));
                end
                gaps[i] = $urandom_range(2, 0);
            end
            convert(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            idle_cycles($urandom_range(2, 0), 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
